// File: rtl/nec_pkg.sv
// NEC IR protocol shared definitions: FSM state encoding, per-state unit
// counts, timing helper and the remote-control button codes used across
// the codebase.
package nec_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    LEADER_MARK  = 3'd1,
    LEADER_SPACE = 3'd2,
    BIT_MARK     = 3'd3,
    BIT_SPACE    = 3'd4,
    STOP_MARK    = 3'd5,
    GUARD        = 3'd6
  } nec_state_e;

  // Durations of each state in units of T (562.5 us)
  localparam logic [4:0] LEADER_MARK_UNITS  = 5'd16;
  localparam logic [4:0] LEADER_SPACE_UNITS = 5'd8;
  localparam logic [4:0] REPEAT_SPACE_UNITS = 5'd4;
  localparam logic [4:0] BIT_MARK_UNITS     = 5'd1;
  localparam logic [4:0] ZERO_SPACE_UNITS   = 5'd1;
  localparam logic [4:0] ONE_SPACE_UNITS    = 5'd3;
  localparam logic [4:0] STOP_MARK_UNITS    = 5'd1;
  localparam logic [4:0] GUARD_UNITS        = 5'd16;

  // Button codes, sent MSB first so a receiver rebuilds the same value
  localparam logic [31:0] NEC_UP    = 32'h20DF02FD;
  localparam logic [31:0] NEC_DOWN  = 32'h20DF827D;
  localparam logic [31:0] NEC_LEFT  = 32'h20DFE01F;
  localparam logic [31:0] NEC_RIGHT = 32'h20DF609F;
  localparam logic [31:0] NEC_ENTER = 32'h20DF5AA5;
  localparam logic [31:0] NEC_MENU  = 32'h20DFC23D;
  localparam logic [31:0] NEC_DIGIT [10] = '{
    32'h20DF08F7, 32'h20DF8877, 32'h20DF48B7, 32'h20DFC837, 32'h20DF28D7,
    32'h20DFA857, 32'h20DF6897, 32'h20DFE817, 32'h20DF18E7, 32'h20DF9867
  };

  // Clocks per unit T = clk_freq * 9 / 16000, widened to avoid overflow
  function automatic int unit_cycles(input int clk_freq);
    longint v;
    v = (longint'(clk_freq) * 64'sd9) / 64'sd16000;
    return int'(v);
  endfunction

  // True for states during which the emitter is driven
  function automatic logic is_mark_state(input nec_state_e s);
    logic m;
    case (s)
      LEADER_MARK, BIT_MARK, STOP_MARK: m = 1'b1;
      default:                          m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// IR carrier generator: square wave of PERIOD clocks, high for the first
// PERIOD/3 clocks. The output is registered and describes the cycle that
// follows the edge; restart forces that cycle to be phase 0.
module ir_carrier_gen #(
  parameter int PERIOD = 1315
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic carrier
);

  localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(PERIOD - 1);
  localparam logic [PW-1:0] HIGH_CYC   = PW'(PERIOD / 3);

  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_phase_next;
  logic          r_carrier;

  // Phase of the upcoming cycle: wrap at the end of a period or on restart
  always_comb begin
    w_phase_next = r_phase;
    if (restart || (r_phase == LAST_PHASE)) begin
      w_phase_next = '0;
    end else begin
      w_phase_next = r_phase + PW'(1);
    end
  end

  // Phase counter and registered carrier level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase   <= '0;
      r_carrier <= 1'b0;
    end else begin
      r_phase   <= w_phase_next;
      r_carrier <= enable && (w_phase_next < HIGH_CYC);
    end
  end

  assign carrier = r_carrier;

endmodule

// File: rtl/nec_transmitter.sv
// NEC IR frame transmitter: leader, 32 data bits MSB first, stop mark and
// guard space; repeat frames skip the data bits. Outputs are registered
// from the next state so ir_out/busy/done line up with the state change.
// Build option NEC_TX_CARRIER_EN: modulate marks with the IR carrier
// (sub-module ir_carrier_gen); otherwise marks are a plain envelope.
module nec_transmitter
  import nec_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int CARRIER_FREQ = 38_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] word,
  input  logic        start,
  input  logic        repeat_req,
  output logic        ir_out,
  output logic        busy,
  output logic        done
);

  localparam int          UNIT_CYCLES    = unit_cycles(CLK_FREQ);
  localparam logic [31:0] UNIT_C         = 32'(UNIT_CYCLES);
  localparam int          CARRIER_PERIOD = CLK_FREQ / CARRIER_FREQ;

  // Marker scope: a carrier period under 3 clocks has no high phase
  if (CARRIER_PERIOD < 3) begin : g_carrier_period_short
  end

  nec_state_e  r_state;
  nec_state_e  w_next_state;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_next;
  logic [4:0]  r_bit_idx;
  logic [4:0]  w_bit_idx_next;
  logic [31:0] r_word;
  logic [31:0] w_word_next;
  logic        r_repeat;
  logic        w_repeat_next;
  logic        r_busy;
  logic        r_done;
  logic [4:0]  w_units;
  logic [31:0] w_dur_m1;
  logic        w_last;
  logic        w_mark_next;

  // Length of the current state in units of T
  always_comb begin
    w_units = 5'd0;
    case (r_state)
      LEADER_MARK:  w_units = LEADER_MARK_UNITS;
      LEADER_SPACE: w_units = r_repeat ? REPEAT_SPACE_UNITS : LEADER_SPACE_UNITS;
      BIT_MARK:     w_units = BIT_MARK_UNITS;
      BIT_SPACE:    w_units = r_word[r_bit_idx] ? ONE_SPACE_UNITS : ZERO_SPACE_UNITS;
      STOP_MARK:    w_units = STOP_MARK_UNITS;
      GUARD:        w_units = GUARD_UNITS;
      default:      w_units = 5'd0;
    endcase
  end

  assign w_dur_m1 = ({27'd0, w_units} * UNIT_C) - 32'd1;
  assign w_last   = (r_cnt == w_dur_m1);

  // Next-state logic: accept requests only in IDLE, walk the frame otherwise
  always_comb begin
    w_next_state   = r_state;
    w_word_next    = r_word;
    w_repeat_next  = r_repeat;
    w_bit_idx_next = r_bit_idx;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state   = LEADER_MARK;
          w_word_next    = word;
          w_repeat_next  = 1'b0;
          w_bit_idx_next = 5'd31;
        end else if (repeat_req) begin
          w_next_state   = LEADER_MARK;
          w_repeat_next  = 1'b1;
          w_bit_idx_next = 5'd31;
        end else begin
          w_next_state = IDLE;
        end
      end
      LEADER_MARK: begin
        if (w_last) begin
          w_next_state = LEADER_SPACE;
        end else begin
          w_next_state = LEADER_MARK;
        end
      end
      LEADER_SPACE: begin
        if (w_last) begin
          w_next_state = r_repeat ? STOP_MARK : BIT_MARK;
        end else begin
          w_next_state = LEADER_SPACE;
        end
      end
      BIT_MARK: begin
        if (w_last) begin
          w_next_state = BIT_SPACE;
        end else begin
          w_next_state = BIT_MARK;
        end
      end
      BIT_SPACE: begin
        if (w_last) begin
          if (r_bit_idx == 5'd0) begin
            w_next_state = STOP_MARK;
          end else begin
            w_next_state   = BIT_MARK;
            w_bit_idx_next = r_bit_idx - 5'd1;
          end
        end else begin
          w_next_state = BIT_SPACE;
        end
      end
      STOP_MARK: begin
        if (w_last) begin
          w_next_state = GUARD;
        end else begin
          w_next_state = STOP_MARK;
        end
      end
      GUARD: begin
        if (w_last) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = GUARD;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Cycle counter within a state: restarts on every state change
  always_comb begin
    w_cnt_next = 32'd0;
    if ((r_state == IDLE) || (w_next_state != r_state)) begin
      w_cnt_next = 32'd0;
    end else begin
      w_cnt_next = r_cnt + 32'd1;
    end
  end

  assign w_mark_next = is_mark_state(w_next_state);

  // State, counters, latched payload and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 32'd0;
      r_bit_idx <= 5'd0;
      r_word    <= 32'd0;
      r_repeat  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_word    <= w_word_next;
      r_repeat  <= w_repeat_next;
      r_busy    <= (w_next_state != IDLE);
      r_done    <= (r_state != IDLE) && (w_next_state == IDLE);
    end
  end

  assign busy = r_busy;
  assign done = r_done;

`ifdef NEC_TX_CARRIER_EN
  logic w_mark_restart;
  logic w_carrier;

  assign w_mark_restart = w_mark_next && (w_next_state != r_state);

  ir_carrier_gen #(
    .PERIOD (CARRIER_PERIOD)
  ) u_carrier (
    .clk     (clk),
    .reset   (reset),
    .restart (w_mark_restart),
    .enable  (w_mark_next),
    .carrier (w_carrier)
  );

  assign ir_out = w_carrier;
`else
  logic r_ir_out;

  // Envelope drive: emitter on for the whole of every mark state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir_out <= 1'b0;
    end else begin
      r_ir_out <= w_mark_next;
    end
  end

  assign ir_out = r_ir_out;
`endif

endmodule

// File: tb/tb_nec_transmitter.sv
// Self-checking bench for nec_transmitter. Envelope build runs at
// CLK_FREQ=16000 (T=9 clocks); with NEC_TX_CARRIER_EN it runs at 50 MHz
// and measures the carrier shape of the first mark.
module tb_nec_transmitter;
  import nec_pkg::*;

`ifdef NEC_TX_CARRIER_EN
  localparam int CLK_FREQ = 50_000_000;
`else
  localparam int CLK_FREQ = 16000;
`endif
  localparam int CARRIER_FREQ = 38_000;
  localparam int T = 9;

  typedef struct {
    bit          is_repeat;
    logic [31:0] word;
    int          total;
  } exp_t;

  typedef struct {
    int          total;
    int          lead_mark;
    int          lead_space;
    int          nbits;
    logic [31:0] word;
    int          bad;
    int          stop_mark;
    int          guard;
  } obs_t;

  logic        clk;
  logic        reset;
  logic [31:0] word;
  logic        start;
  logic        repeat_req;
  logic        ir_out;
  logic        busy;
  logic        done;

  exp_t exp_q[$];
  obs_t obs_q[$];
  bit   cur_q[$];
  int   n_vec;
  int   n_err;
  int   overlap_cnt;
  int   idle_ir_cnt;

  nec_transmitter #(
    .CLK_FREQ     (CLK_FREQ),
    .CARRIER_FREQ (CARRIER_FREQ)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .word       (word),
    .start      (start),
    .repeat_req (repeat_req),
    .ir_out     (ir_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Split the captured busy-window samples into runs and decode the frame
  function automatic obs_t decode_cur();
    obs_t o;
    int   rv[$];
    int   rl[$];
    int   n;
    o = '{default: 0};
    o.total = cur_q.size();
    foreach (cur_q[i]) begin
      if (i == 0) begin
        rv.push_back(int'(cur_q[i])); rl.push_back(1);
      end else if (cur_q[i] != cur_q[i-1]) begin
        rv.push_back(int'(cur_q[i])); rl.push_back(1);
      end else begin
        rl[rl.size()-1] = rl[rl.size()-1] + 1;
      end
    end
    n = rl.size();
    if (n < 4 || rv[0] != 1) begin
      o.bad = 1000;
      return o;
    end
    o.lead_mark  = rl[0];
    o.lead_space = rl[1];
    o.stop_mark  = rl[n-2];
    o.guard      = rl[n-1];
    o.nbits      = (n - 4) / 2;
    for (int k = 0; k < o.nbits; k++) begin
      if (rl[2+2*k] != T) o.bad++;
      if (rl[3+2*k] == 3*T) begin
        o.word = {o.word[30:0], 1'b1};
      end else begin
        if (rl[3+2*k] != T) o.bad++;
        o.word = {o.word[30:0], 1'b0};
      end
    end
    return o;
  endfunction

  // Monitor: capture ir_out while busy, decode on done, track idle hygiene
  always @(negedge clk) begin
    if (reset) begin
      cur_q.delete();
    end else begin
      if (busy === 1'b1) begin
        cur_q.push_back(ir_out);
      end else begin
        if (ir_out !== 1'b0) idle_ir_cnt++;
        if (done === 1'b1) begin
          obs_q.push_back(decode_cur());
          cur_q.delete();
        end
      end
      if (done === 1'b1 && busy === 1'b1) overlap_cnt++;
    end
  end

  function automatic int full_total(input logic [31:0] w);
    return (16 + 8 + 64 + 2 * $countones(w) + 1 + 16) * T;
  endfunction

  task automatic push_full(input logic [31:0] w);
    exp_t e;
    e.is_repeat = 1'b0; e.word = w; e.total = full_total(w);
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] w, input bit s, input bit r);
    @(negedge clk);
    word = w; start = s; repeat_req = r;
    @(negedge clk);
    start = 1'b0; repeat_req = 1'b0;
  endtask

  task automatic wait_obs(input int budget, output bit got);
    int c;
    c = 0;
    got = 1'b0;
    while (!got && c < budget) begin
      @(negedge clk); #1;
      c++;
      if (obs_q.size() > 0) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; repeat_req = 1'b0; word = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    n_vec++; if (ir_out !== 1'b0) begin n_err++; $display("FAIL reset_ir_out got=%b want=0", ir_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_idle busy=%b want=0", busy); end
  endtask

  task automatic test_zero_frame();
    exp_t e; obs_t o; bit got;
    push_full(32'h0000_0000);
    send(32'h0000_0000, 1'b1, 1'b0);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL zero_busy_rise got=%b want=1", busy); end
    wait_obs(2000, got);
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL zero_timeout no done within budget");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++; if (o.total !== 945) begin n_err++; $display("FAIL zero_total got=%0d want=945", o.total); end
      n_vec++; if (o.total !== e.total) begin n_err++; $display("FAIL zero_total_model got=%0d want=%0d", o.total, e.total); end
      n_vec++; if (o.lead_mark !== 16*T) begin n_err++; $display("FAIL zero_lead_mark got=%0d want=%0d", o.lead_mark, 16*T); end
      n_vec++; if (o.lead_space !== 8*T) begin n_err++; $display("FAIL zero_lead_space got=%0d want=%0d", o.lead_space, 8*T); end
      n_vec++; if (o.nbits !== 32) begin n_err++; $display("FAIL zero_nbits got=%0d want=32", o.nbits); end
      n_vec++; if (o.word !== e.word) begin n_err++; $display("FAIL zero_word got=%h want=%h", o.word, e.word); end
      n_vec++; if (o.bad !== 0) begin n_err++; $display("FAIL zero_bit_shape got=%0d bad want=0", o.bad); end
      n_vec++; if (o.stop_mark !== T) begin n_err++; $display("FAIL zero_stop got=%0d want=%0d", o.stop_mark, T); end
      n_vec++; if (o.guard !== 16*T) begin n_err++; $display("FAIL zero_guard got=%0d want=%0d", o.guard, 16*T); end
    end
  endtask

  task automatic test_enter_frame();
    exp_t e; obs_t o; bit got;
    push_full(NEC_ENTER);
    send(NEC_ENTER, 1'b1, 1'b0);
    wait_obs(2000, got);
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL enter_timeout no done within budget");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++; if (o.total !== 137*T) begin n_err++; $display("FAIL enter_total got=%0d want=%0d", o.total, 137*T); end
      n_vec++; if (o.word !== 32'h20DF5AA5) begin n_err++; $display("FAIL enter_word got=%h want=20df5aa5", o.word); end
      n_vec++; if (o.bad !== 0) begin n_err++; $display("FAIL enter_bit_shape got=%0d bad want=0", o.bad); end
      n_vec++; if (o.total !== e.total) begin n_err++; $display("FAIL enter_total_model got=%0d want=%0d", o.total, e.total); end
    end
  endtask

  task automatic test_repeat();
    exp_t e; obs_t o; bit got;
    e.is_repeat = 1'b1; e.word = 32'h0; e.total = 37 * T;
    exp_q.push_back(e);
    send(NEC_MENU, 1'b0, 1'b1);
    wait_obs(2000, got);
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL repeat_timeout no done within budget");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++; if (o.total !== e.total) begin n_err++; $display("FAIL repeat_total got=%0d want=%0d", o.total, e.total); end
      n_vec++; if (o.lead_mark !== 16*T) begin n_err++; $display("FAIL repeat_lead_mark got=%0d want=%0d", o.lead_mark, 16*T); end
      n_vec++; if (o.lead_space !== 4*T) begin n_err++; $display("FAIL repeat_lead_space got=%0d want=%0d", o.lead_space, 4*T); end
      n_vec++; if (o.nbits !== 0) begin n_err++; $display("FAIL repeat_nbits got=%0d want=0", o.nbits); end
      n_vec++; if (o.stop_mark !== T) begin n_err++; $display("FAIL repeat_stop got=%0d want=%0d", o.stop_mark, T); end
      n_vec++; if (o.guard !== 16*T) begin n_err++; $display("FAIL repeat_guard got=%0d want=%0d", o.guard, 16*T); end
    end
  endtask

  task automatic test_priority_and_ignore();
    exp_t e; obs_t o; bit got;
    push_full(NEC_UP);
    send(NEC_UP, 1'b1, 1'b1);
    repeat (50) @(negedge clk);
    word = NEC_DOWN; start = 1'b1; repeat_req = 1'b1;
    @(negedge clk);
    start = 1'b0; repeat_req = 1'b0;
    wait_obs(2000, got);
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL prio_timeout no done within budget");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++; if (o.lead_space !== 8*T) begin n_err++; $display("FAIL prio_full_frame lead_space got=%0d want=%0d", o.lead_space, 8*T); end
      n_vec++; if (o.word !== e.word) begin n_err++; $display("FAIL prio_word got=%h want=%h", o.word, e.word); end
      n_vec++; if (o.total !== e.total) begin n_err++; $display("FAIL prio_total got=%0d want=%0d", o.total, e.total); end
    end
    repeat (5) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_no_second_frame busy=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    exp_t e; obs_t o; bit got;
    push_full(NEC_DIGIT[5]);
    push_full(NEC_RIGHT);
    @(negedge clk);
    word = NEC_DIGIT[5]; start = 1'b1;
    repeat (20) @(negedge clk);
    word = NEC_RIGHT;
    wait_obs(2000, got);
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL b2b_timeout first frame");
    end else begin
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_done_cycle busy=%b want=0", busy); end
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done_pulse done=%b want=1", done); end
      @(negedge clk);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_next busy=%b want=1", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_width done=%b want=0", done); end
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++; if (o.word !== e.word) begin n_err++; $display("FAIL b2b_first_word got=%h want=%h", o.word, e.word); end
    end
    start = 1'b0;
    wait_obs(2000, got);
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL b2b_timeout second frame");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++; if (o.word !== e.word) begin n_err++; $display("FAIL b2b_second_word got=%h want=%h", o.word, e.word); end
      n_vec++; if (o.total !== e.total) begin n_err++; $display("FAIL b2b_second_total got=%0d want=%0d", o.total, e.total); end
    end
  endtask

  task automatic test_reset_midframe();
    exp_t e; obs_t o; bit got;
    send(32'h0000_0000, 1'b1, 1'b0);
    // Cycle 597 after acceptance lies inside the mark of bit index 10
    repeat (597) @(negedge clk);
    n_vec++; if (ir_out !== 1'b1) begin n_err++; $display("FAIL midreset_in_mark ir_out=%b want=1", ir_out); end
    #1 reset = 1'b1;
    #1;
    n_vec++; if (ir_out !== 1'b0) begin n_err++; $display("FAIL midreset_ir_out got=%b want=0", ir_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy got=%b want=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done got=%b want=0", done); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push_full(NEC_LEFT);
    send(NEC_LEFT, 1'b1, 1'b0);
    wait_obs(2000, got);
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL midreset_timeout clean frame");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++; if (o.word !== e.word) begin n_err++; $display("FAIL midreset_word got=%h want=%h", o.word, e.word); end
      n_vec++; if (o.total !== e.total) begin n_err++; $display("FAIL midreset_total got=%0d want=%0d", o.total, e.total); end
      n_vec++; if (o.bad !== 0) begin n_err++; $display("FAIL midreset_shape got=%0d bad want=0", o.bad); end
    end
  endtask

  task automatic test_carrier();
    int  exp_len [4];
    int  len;
    logic cur;
    exp_len[0] = 438; exp_len[1] = 877; exp_len[2] = 438; exp_len[3] = 877;
    send(NEC_ENTER, 1'b1, 1'b0);
    #1;
    n_vec++; if (ir_out !== 1'b1) begin n_err++; $display("FAIL carrier_first_high got=%b want=1", ir_out); end
    for (int r = 0; r < 4; r++) begin
      cur = ir_out;
      len = 0;
      while (ir_out === cur && len < 2000) begin
        len++;
        @(negedge clk); #1;
      end
      n_vec++; if (len !== exp_len[r]) begin n_err++; $display("FAIL carrier_run%0d got=%0d want=%0d", r, len, exp_len[r]); end
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_vec++; if (ir_out !== 1'b0) begin n_err++; $display("FAIL carrier_reset_ir got=%b want=0", ir_out); end
  endtask

  task automatic test_idle_hygiene();
    n_vec++; if (overlap_cnt !== 0) begin n_err++; $display("FAIL done_busy_overlap got=%0d want=0", overlap_cnt); end
    n_vec++; if (idle_ir_cnt !== 0) begin n_err++; $display("FAIL idle_ir_high got=%0d want=0", idle_ir_cnt); end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
  endtask

  // Hard stop in case something unforeseen stalls the sequence
  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; overlap_cnt = 0; idle_ir_cnt = 0;
    test_reset();
`ifdef NEC_TX_CARRIER_EN
    test_carrier();
`else
    test_zero_frame();
    test_enter_frame();
    test_repeat();
    test_priority_and_ignore();
    test_back_to_back();
    test_reset_midframe();
`endif
    test_idle_hygiene();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nec_transmitter.md
NEC_TRANSMITTER -- requirements
Module: nec_transmitter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter CARRIER_FREQ, default 38_000, IR carrier frequency in Hz.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port word, input, 32, NEC frame payload; word[31] is transmitted first, so an NEC receiver reassembles the identical value (e.g. 32'h20DF5AA5 = ENTER).
REQ-006 SHALL have port start, input, 1, request a full frame; sampled only in IDLE.
REQ-007 SHALL have port repeat_req, input, 1, request an NEC repeat frame; sampled only in IDLE.
REQ-008 SHALL have port ir_out, output, 1, IR LED drive; 1 = emitter on.
REQ-009 SHALL have port busy, output, 1, high from the cycle after acceptance until the return to IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse on the return to IDLE.

Function
REQ-011 SHALL define unit time T = UNIT_CYCLES = CLK_FREQ*9/16000 clocks (562.5 us; 28125 at 50 MHz), using integer division.
REQ-012 SHALL implement states IDLE, LEADER_MARK, LEADER_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK and GUARD.
REQ-013 SHALL, in IDLE with start=1, latch word and enter LEADER_MARK on the next edge; busy SHALL rise on that same edge.
REQ-014 SHALL, in IDLE with repeat_req=1 and start=0, enter LEADER_MARK flagged as a repeat frame; start SHALL win when both are high.
REQ-015 SHALL ignore start and repeat_req while busy=1; the latched word SHALL NOT change mid-frame.
REQ-016 SHALL use these state durations:
- LEADER_MARK: 16T mark.
- LEADER_SPACE: 8T space for a full frame, 4T space for a repeat frame.
- BIT_MARK: 1T mark.
- BIT_SPACE: 1T space for bit 0, 3T space for bit 1.
- STOP_MARK: 1T mark.
- GUARD: 16T space.
REQ-017 SHALL send exactly 32 BIT_MARK/BIT_SPACE pairs in a full frame (bit index 31 down to 0) and skip the bit states entirely in a repeat frame (LEADER_SPACE goes to STOP_MARK).
REQ-018 SHALL give a full frame a duration of (16+8+64+2*popcount(word)+1+16)*T clocks from acceptance to done, exact to the cycle.
REQ-019 SHALL give a repeat frame a duration of (16+4+1+16)*T = 37T clocks.
REQ-020 SHALL assert done for exactly one cycle, coincident with busy falling; a start present in that cycle SHALL NOT be accepted until the following cycle.
REQ-021 SHALL drive ir_out=0 in every space state and in IDLE.

Reset
REQ-022 SHALL, while reset=1, force ir_out=0, busy=0 and done=0, the state to IDLE, and all counters and the latched word to 0, asynchronously, including mid-frame.
REQ-023 SHALL accept no request in the first edge after reset deasserts unless start or repeat_req is high at that edge, in which case normal acceptance applies.

Configuration
REQ-024 SHALL use macro NEC_TX_CARRIER_EN to select the mark waveform.
REQ-025 SHALL, with NEC_TX_CARRIER_EN defined, modulate marks with a carrier of period P = CLK_FREQ/CARRIER_FREQ clocks, high for the first P/3 clocks of each period, with the carrier phase restarting at the first cycle of every mark state.
REQ-026 SHALL, without NEC_TX_CARRIER_EN, drive ir_out=1 for the whole of every mark (envelope only), with no carrier logic present.

Structure
REQ-027 SHALL place the state enum, the unit counts (16, 8, 4, 1, 3, 16) and the shared NEC button codes (UP, DOWN, LEFT, RIGHT, ENTER, MENU, digit codes) in package nec_pkg.
REQ-028 SHALL implement the carrier as sub-module ir_carrier_gen (clk, reset, restart, enable -> carrier), instantiated only under NEC_TX_CARRIER_EN.

Verification
All scenarios use CLK_FREQ=16000, so T=9 clocks; envelope build unless noted.
REQ-029 SHALL cover: word=32'h00000000 with start pulse -> 16T mark, 8T space, 32x(1T mark, 1T space), 1T mark, 16T guard; done at 105T=945 clocks.
REQ-030 SHALL cover: word=32'h20DF5AA5 -> 16 ones give 137T clocks; bit spaces decoded MSB-first reproduce 32'h20DF5AA5.
REQ-031 SHALL cover: repeat_req pulse -> 16T mark, 4T space, 1T mark, 16T guard; done at 37T=333 clocks; no bit marks.
REQ-032 SHALL cover: start and repeat_req high together in IDLE -> full frame sent; start pulsed mid-frame with a different word -> ignored and the original word transmitted.
REQ-033 SHALL cover: reset asserted at bit 10 of a frame -> ir_out, busy and done drop to 0 with no clock edge; a later start sends a full, clean frame.
REQ-034 SHALL cover, with NEC_TX_CARRIER_EN, CLK_FREQ=50_000_000 and CARRIER_FREQ=38_000 (P=1315): each mark toggles with 438 clocks high and 877 clocks low, and the first mark cycle is high.
